// File: rtl/axis_frame_generator.sv
// ============================================================================
// Module  : axis_frame_generator
// Brief   : AXI4-Stream test-frame source with selectable payload patterns,
//           inter-frame gap, frame-count limit and run statistics.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_frame_generator #(
  parameter int AXIS_DATA_WIDTH = 256,
  parameter int AXIS_DATA_KEEP  = 32,
  parameter int AXIS_DATA_DEPTH = 400,
  parameter int NUM_CHANNELS    = 4,
  parameter int FRAME_GAP       = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [1:0]                 mode,
  input  logic [15:0]                frame_limit,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [AXIS_DATA_KEEP-1:0]  m_axis_tkeep,
  output logic                       m_axis_tlast,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       busy,
  output logic                       frame_done,
  output logic [31:0]                frames_sent,
  output logic [31:0]                stall_cycles
);

  localparam int LANE_W = AXIS_DATA_WIDTH / NUM_CHANNELS;
  localparam int BEAT_W = $clog2(AXIS_DATA_DEPTH);
  localparam int GAP_W  = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
  localparam logic [31:0]       LFSR_SEED = 32'hACE1_0001;
  // Right-shift Galois taps for x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0]       LFSR_TAPS = 32'h8020_0003;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(AXIS_DATA_DEPTH - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [1:0]        mode_q, mode_d;
  logic [31:0]       lfsr_q, lfsr_d;
  logic [31:0]       frames_q, frames_d;
  logic [31:0]       stalls_q, stalls_d;

  logic        valid;
  logic        last_beat;
  logic        limit_hit;
  logic [31:0] lfsr_next;

  assign valid     = (state_q == S_RUN);
  assign last_beat = (beat_q == LAST_BEAT);
  assign limit_hit = (frame_limit != 16'd0) &&
                     (({1'b0, frames_q} + 33'd1) == {17'd0, frame_limit});
  assign lfsr_next = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      beat_q   <= '0;
      gap_q    <= '0;
      mode_q   <= 2'd0;
      lfsr_q   <= LFSR_SEED;
      frames_q <= '0;
      stalls_q <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      gap_q    <= gap_d;
      mode_q   <= mode_d;
      lfsr_q   <= lfsr_d;
      frames_q <= frames_d;
      stalls_q <= stalls_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    gap_d    = gap_q;
    mode_d   = mode_q;
    lfsr_d   = lfsr_q;
    frames_d = frames_q;
    stalls_d = stalls_q;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d  = S_RUN;
          mode_d   = mode;
          beat_d   = '0;
          frames_d = '0;
          stalls_d = '0;
        end
      end
      S_RUN: begin
        if (!m_axis_tready && (stalls_q != 32'hFFFF_FFFF)) begin
          stalls_d = stalls_q + 32'd1;
        end
        if (m_axis_tready) begin
          lfsr_d = lfsr_next;
          if (last_beat) begin
            beat_d = '0;
            if (frames_q != 32'hFFFF_FFFF) begin
              frames_d = frames_q + 32'd1;
            end
            // Limit outranks a pending disable, which outranks the gap
            if (limit_hit) begin
              state_d = S_DONE;
            end else if (!enable) begin
              state_d = S_IDLE;
            end else if (FRAME_GAP > 0) begin
              state_d = S_GAP;
              gap_d   = '0;
            end else begin
              mode_d = mode;
            end
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = enable ? S_RUN : S_IDLE;
          mode_d  = mode;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      S_DONE: begin
        if (!enable) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic [LANE_W-1:0] lfsr_lane;
  assign lfsr_lane = {(LANE_W / 32){lfsr_q}};

  generate
    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_lane
      logic [LANE_W-1:0] cnt_val;
      logic [LANE_W-1:0] lane_val;

      assign cnt_val = LANE_W'(beat_q) * LANE_W'(NUM_CHANNELS) + LANE_W'(i);

      always_comb begin
        lane_val = '0;
        case (mode_q)
          2'd0: lane_val = cnt_val;
          2'd1: lane_val = lfsr_lane ^ LANE_W'(i);
          2'd2: begin
            if (beat_q != '0) begin
              lane_val = cnt_val;
            end else if (i == 0) begin
              lane_val = LANE_W'(frames_q);
            end else if (i == 1) begin
              lane_val = LANE_W'(AXIS_DATA_DEPTH);
            end
          end
          default: lane_val = '0;
        endcase
      end

      assign m_axis_tdata[i*LANE_W +: LANE_W] = valid ? lane_val : '0;
    end
  endgenerate

  assign m_axis_tvalid = valid;
  assign m_axis_tkeep  = {AXIS_DATA_KEEP{valid}};
  assign m_axis_tlast  = valid & last_beat;
  assign frame_done    = valid & m_axis_tready & last_beat;
  assign busy          = (state_q != S_IDLE);
  assign frames_sent   = frames_q;
  assign stall_cycles  = stalls_q;

endmodule

`default_nettype wire

// File: tb/tb_axis_frame_generator.sv
// Bench for axis_frame_generator: directed scenarios with randomized backpressure,
// checked against a beat-level payload/LFSR reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_axis_frame_generator;

  localparam int DW    = 256;
  localparam int KW    = 32;
  localparam int DEPTH = 400;
  localparam int NCH   = 4;
  localparam int LW    = DW / NCH;
  localparam int GAP   = 16;
  localparam logic [31:0] SEED = 32'hACE1_0001;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [1:0]    mode;
  logic [15:0]   frame_limit;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          busy;
  logic          frame_done;
  logic [31:0]   frames_sent;
  logic [31:0]   stall_cycles;

  axis_frame_generator #(
    .AXIS_DATA_WIDTH(DW),
    .AXIS_DATA_KEEP (KW),
    .AXIS_DATA_DEPTH(DEPTH),
    .NUM_CHANNELS   (NCH),
    .FRAME_GAP      (GAP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .mode         (mode),
    .frame_limit  (frame_limit),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .busy         (busy),
    .frame_done   (frame_done),
    .frames_sent  (frames_sent),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  int          tests  = 0;
  int          failed = 0;
  logic [31:0] mdl_lfsr;
  int          mdl_stalls;
  int          done_cnt;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Galois step built from the polynomial's exponent list
  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    int          exps [4] = '{32, 22, 2, 1};
    logic [31:0] mask = '0;
    logic        out;
    foreach (exps[k]) mask[exps[k]-1] = 1'b1;
    out = l[0];
    l   = l >> 1;
    if (out) l = l ^ mask;
    return l;
  endfunction

  function automatic logic [DW-1:0] exp_beat(input int m, input int b, input int f,
                                             input logic [31:0] l);
    logic [DW-1:0] d = '0;
    logic [LW-1:0] lane;
    for (int i = 0; i < NCH; i++) begin
      case (m)
        0:       lane = LW'(b * NCH + i);
        1:       lane = {l, l} ^ LW'(i);
        2:       lane = (b != 0) ? LW'(b * NCH + i) :
                        (i == 0) ? LW'(f) : (i == 1) ? LW'(DEPTH) : '0;
        default: lane = '0;
      endcase
      d[i*LW +: LW] = lane;
    end
    return d;
  endfunction

  // Entered and left at a negedge; the model expects tvalid=1 until the tlast handshake.
  task automatic run_frame(input int m, input int f, input int rdy_pct,
                           input int off_beat, input int abort_beat);
    int b     = 0;
    int guard = 0;
    bit fin   = 0;
    bit hs;
    while (!fin) begin
      check("tvalid", DW'(m_axis_tvalid), DW'(1'b1));
      check("tdata", m_axis_tdata, exp_beat(m, b, f, mdl_lfsr));
      check("tlast", DW'(m_axis_tlast), DW'(b == DEPTH - 1));
      check("tkeep", DW'(m_axis_tkeep), DW'({KW{1'b1}}));
      check("frames_sent_in_frame", DW'(frames_sent), DW'(f));
      if (b == abort_beat) begin
        m_axis_tready = 1'b0;
        return;
      end
      if (b == off_beat) begin
        enable = 1'b0;
        mode   = 2'd3;
      end
      m_axis_tready = ($urandom_range(99) < rdy_pct);
      #1;
      check("frame_done", DW'(frame_done), DW'(m_axis_tready && (b == DEPTH - 1)));
      if (frame_done === 1'b1) done_cnt++;
      hs = m_axis_tready;
      if (!hs) mdl_stalls++;
      @(posedge clk);
      if (hs) begin
        mdl_lfsr = lfsr_step(mdl_lfsr);
        if (b == DEPTH - 1) fin = 1;
        else b++;
      end
      @(negedge clk);
      guard++;
      if (guard > 4000) begin
        check("frame_cycle_budget", DW'(1'b0), DW'(1'b1));
        return;
      end
    end
  endtask

  task automatic wait_gap();
    int idle = 0;
    while (m_axis_tvalid !== 1'b1 && idle < 64) begin
      check("busy_in_gap", DW'(busy), DW'(1'b1));
      idle++;
      @(negedge clk);
    end
    check("gap_length", DW'(idle), DW'(GAP));
  endtask

  task automatic start_run(input logic [1:0] m, input logic [15:0] lim);
    mode          = m;
    frame_limit   = lim;
    enable        = 1'b1;
    m_axis_tready = 1'b1;
    mdl_stalls    = 0;
    done_cnt      = 0;
    #1;
    check("tvalid_latency", DW'(m_axis_tvalid), DW'(1'b0));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      check(tag, DW'(m_axis_tvalid), DW'(1'b0));
      @(negedge clk);
    end
  endtask

  task automatic stop_run();
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("busy_after_disable", DW'(busy), DW'(1'b0));
  endtask

  initial begin
    rst_n         = 1'b0;
    enable        = 1'b0;
    mode          = 2'd0;
    frame_limit   = 16'd0;
    m_axis_tready = 1'b0;
    mdl_lfsr      = SEED;
    mdl_stalls    = 0;
    done_cnt      = 0;
    repeat (3) @(negedge clk);
    check("rst_tvalid", DW'(m_axis_tvalid), DW'(1'b0));
    check("rst_tdata", m_axis_tdata, '0);
    check("rst_busy", DW'(busy), DW'(1'b0));
    check("rst_frames", DW'(frames_sent), DW'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single counter frame, then DONE
    start_run(2'd0, 16'd1);
    run_frame(0, 0, 100, -1, -1);
    check("t1_done_tvalid", DW'(m_axis_tvalid), DW'(1'b0));
    check("t1_done_busy", DW'(busy), DW'(1'b1));
    check("t1_frames", DW'(frames_sent), DW'(1));
    check("t1_done_pulses", DW'(done_cnt), DW'(1));
    idle_cycles(5, "t1_done_hold");
    stop_run();

    // 2: three frames separated by the gap
    start_run(2'd0, 16'd3);
    for (int k = 0; k < 3; k++) begin
      run_frame(0, k, 100, -1, -1);
      if (k < 2) wait_gap();
    end
    check("t2_done_busy", DW'(busy), DW'(1'b1));
    check("t2_frames", DW'(frames_sent), DW'(3));
    idle_cycles(GAP + 8, "t2_done_hold");
    stop_run();

    // 3: LFSR payload under random backpressure
    start_run(2'd1, 16'd2);
    run_frame(1, 0, 50, -1, -1);
    wait_gap();
    run_frame(1, 1, 50, -1, -1);
    check("t3_frames", DW'(frames_sent), DW'(2));
    check("t3_stalls", DW'(stall_cycles), DW'(mdl_stalls));
    stop_run();

    // 4: header+counter frames
    start_run(2'd2, 16'd2);
    run_frame(2, 0, 100, -1, -1);
    wait_gap();
    run_frame(2, 1, 100, -1, -1);
    check("t4_frames", DW'(frames_sent), DW'(2));
    stop_run();

    // 5: disable (and mode change) mid-frame completes the frame, then IDLE
    start_run(2'd0, 16'd0);
    run_frame(0, 0, 100, 100, -1);
    check("t5_busy", DW'(busy), DW'(1'b0));
    check("t5_frames", DW'(frames_sent), DW'(1));
    idle_cycles(GAP + 8, "t5_no_partial");
    mode = 2'd0;

    // 6: asynchronous reset while stalled mid-frame
    start_run(2'd1, 16'd0);
    run_frame(1, 0, 100, -1, 200);
    @(negedge clk);
    check("t6_stalled_valid", DW'(m_axis_tvalid), DW'(1'b1));
    #2;
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    check("t6_rst_tvalid", DW'(m_axis_tvalid), DW'(1'b0));
    check("t6_rst_tdata", m_axis_tdata, '0);
    check("t6_rst_tkeep", DW'(m_axis_tkeep), DW'(0));
    check("t6_rst_busy", DW'(busy), DW'(1'b0));
    check("t6_rst_stalls", DW'(stall_cycles), DW'(0));
    @(negedge clk);
    rst_n    = 1'b1;
    mdl_lfsr = SEED;
    @(negedge clk);
    start_run(2'd1, 16'd1);
    run_frame(1, 0, 100, -1, -1);
    check("t6_frames", DW'(frames_sent), DW'(1));
    stop_run();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time budget expired");
    $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
